stream_to_onchip_mem_writer: RTL and testbench

- Avalon-ST sink to Avalon-MM master that fills the 32-bit single-port on-chip memory with a packet of words from a stream.
- Sits directly upstream of the on-chip memory slave.
- Optional verify pass reads the region back and compares a 32-bit additive checksum of read data against the checksum of written data.
- Software/sequencer drives it through start/base/length ports.

---
 rtl/stream_mem_pkg.sv | 20 ++
 rtl/memwr_addr_gen.sv | 50 +++++
 rtl/stream_to_onchip_mem_writer.sv | 208 ++++++++++++++++++++
 tb/tb_stream_to_onchip_mem_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mem_pkg.sv
// Shared definitions for the stream-to-on-chip-memory writer.
// Contents: controller state encoding, default memory geometry, and the
// all-ones byteenable pattern (wide enough for any supported DATA_W).
package stream_mem_pkg;

  localparam int DEPTH_DEF  = 30720;
  localparam int ADDR_W_DEF = 15;

  localparam int              MAX_BE_W   = 64;
  localparam logic [MAX_BE_W-1:0] BYTEEN_ALL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_FLUSH,
    S_DONE
  } state_e;

endpackage

// File: rtl/memwr_addr_gen.sv
// Loadable word-address pointer for the memory writer.
// load has priority over inc. Incrementing from DEPTH-1 wraps to 0, so the
// pointer never leaves the legal range once loaded with a legal address.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (pointer -> 0)
//   load        - load load_addr into the pointer
//   load_addr   - address to load
//   inc         - advance pointer by one word (with wrap)
//   ptr         - current pointer value
module memwr_addr_gen
  import stream_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_addr;
    end else if (inc) begin
      if (ptr_q == ADDR_W'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/stream_to_onchip_mem_writer.sv
// Avalon-ST sink feeding an Avalon-MM master that fills a single-port
// on-chip memory with a packet of words, with an optional read-back pass
// comparing additive checksums of written and read data.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   start/abort              - one-cycle request / cancel
//   base_addr/length         - first word address / word count
//   snk_data/valid/ready     - stream sink
//   mem_*                    - memory master (no waitrequest, read latency 1)
//   busy/done/error          - status (error sticky until next accepted start)
//   wr_sum/rd_sum            - checksums of written / read-back words
module stream_to_onchip_mem_writer
  import stream_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = 32,
  parameter int VERIFY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           length,
  input  logic [DATA_W-1:0]     snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     wr_sum,
  output logic [DATA_W-1:0]     rd_sum
);

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc + word;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   wr_sum_q, wr_sum_d;
  logic [DATA_W-1:0]   rd_sum_q, rd_sum_d;
  logic                err_q, err_d;
  logic                rd_pend_q, rd_pend_d;

  logic                ag_load;
  logic [ADDR_W-1:0]   ag_load_addr;
  logic                ag_inc;
  logic [ADDR_W-1:0]   ptr;
  logic                last_word;

  memwr_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (ag_load),
    .load_addr (ag_load_addr),
    .inc       (ag_inc),
    .ptr       (ptr)
  );

  assign last_word = (cnt_q == len_q - 16'd1);

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    wr_sum_d       = wr_sum_q;
    rd_sum_d       = rd_sum_q;
    err_d          = err_q;
    rd_pend_d      = 1'b0;
    ag_load        = 1'b0;
    ag_load_addr   = base_q;
    ag_inc         = 1'b0;
    snk_ready      = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;

    if (state_q != S_IDLE && abort) begin
      // Cancel wins over any coincident beat; a pending read return is dropped.
      state_d = S_DONE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (length == 16'd0) begin
              state_d = S_DONE;
              err_d   = 1'b0;
            end else if (32'(length) > 32'(DEPTH) || 32'(base_addr) >= 32'(DEPTH)) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              base_d       = base_addr;
              len_d        = length;
              cnt_d        = '0;
              wr_sum_d     = '0;
              rd_sum_d     = '0;
              err_d        = 1'b0;
              ag_load      = 1'b1;
              ag_load_addr = base_addr;
              state_d      = S_WRITE;
            end
          end
        end

        S_WRITE: begin
          snk_ready = 1'b1;
          if (snk_valid) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_writedata  = snk_data;
            ag_inc         = 1'b1;
            cnt_d          = cnt_q + 16'd1;
            wr_sum_d       = csum_add(wr_sum_q, snk_data);
            if (last_word) begin
              if (VERIFY != 0) begin
                // Rewind the shared pointer for the read-back pass.
                ag_load = 1'b1;
                cnt_d   = '0;
                state_d = S_VERIFY;
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end

        S_VERIFY: begin
          mem_chipselect = 1'b1;
          ag_inc         = 1'b1;
          rd_pend_d      = 1'b1;
          cnt_d          = cnt_q + 16'd1;
          if (rd_pend_q) begin
            rd_sum_d = csum_add(rd_sum_q, mem_readdata);
          end
          if (last_word) begin
            state_d = S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (rd_pend_q) begin
            rd_sum_d = csum_add(rd_sum_q, mem_readdata);
          end
          // Compare with the final sum so error is valid alongside done.
          err_d   = (rd_sum_d != wr_sum_q);
          state_d = S_DONE;
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wr_sum_q  <= wr_sum_d;
      rd_sum_q  <= rd_sum_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign mem_address    = mem_chipselect ? ptr : '0;
  assign mem_byteenable = BYTEEN_ALL[DATA_W/8-1:0];
  assign mem_clken      = 1'b1;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign error          = err_q;
  assign wr_sum         = wr_sum_q;
  assign rd_sum         = rd_sum_q;

endmodule

// File: tb/tb_stream_to_onchip_mem_writer.sv
// Directed bench for stream_to_onchip_mem_writer with a behavioural memory
// model and write/read scoreboards.
module tb_stream_to_onchip_mem_writer;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int DEP = 30720;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [AW-1:0] base_addr;
  logic [15:0]   length;
  logic [DW-1:0] snk_data;
  logic          snk_valid, snk_ready;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic          busy, done, error;
  logic [DW-1:0] wr_sum, rd_sum;

  stream_to_onchip_mem_writer #(
    .ADDR_W (AW), .DEPTH (DEP), .DATA_W (DW), .VERIFY (1)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .base_addr (base_addr), .length (length),
    .snk_data (snk_data), .snk_valid (snk_valid), .snk_ready (snk_ready),
    .mem_address (mem_address), .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect), .mem_write (mem_write),
    .mem_writedata (mem_writedata), .mem_clken (mem_clken),
    .mem_readdata (mem_readdata),
    .busy (busy), .done (done), .error (error),
    .wr_sum (wr_sum), .rd_sum (rd_sum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  logic [DW-1:0] mem [0:DEP-1];
  logic          corrupt = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory: one-cycle read latency; address 2 optionally returns bit 0 flipped.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else mem_readdata <= mem[mem_address] ^ ((corrupt && mem_address == AW'(2)) ? 32'd1 : 32'd0);
    end
  end

  // Scoreboard on every memory access.
  always @(negedge clk) begin : mon
    wr_t           e;
    logic [AW-1:0] ra;
    if (!reset && mem_chipselect) begin
      check("addr_in_range", 32'(32'(mem_address) < 32'(DEP)), 32'd1);
      if (mem_write) begin
        check("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("wr_addr", 32'(mem_address), 32'(e.a));
          check("wr_data", mem_writedata, e.d);
        end
      end else begin
        check("read_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          ra = rq.pop_front();
          check("rd_addr", 32'(mem_address), 32'(ra));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic ab);
    tick();
    start     = 1'b0;
    abort     = ab;
    snk_valid = v;
    snk_data  = d;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [15:0] l);
    tick();
    start     = 1'b1;
    base_addr = b;
    length    = l;
  endtask

  task automatic expect_xfer(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wq.push_back('{a: a, d: d});
    rq.push_back(a);
  endtask

  // Returns the negedge count at which done is seen, 999 on timeout.
  task automatic wait_done(output int n);
    n = 999;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      abort     = 1'b0;
      snk_valid = 1'b0;
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    snk_data = '0; snk_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_ready", 32'(snk_ready), 32'd0);
    check("rst_be", 32'(mem_byteenable), 32'hF);
    check("rst_clken", 32'(mem_clken), 32'd1);
    check("rst_wrsum", wr_sum, 32'd0);

    // Back-to-back packet at base 0.
    for (int i = 0; i < 4; i++) expect_xfer(AW'(i), 32'(i + 1));
    do_start(0, 4);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i + 1), 1'b0);
    wait_done(n);
    check("t1_done_lat", 32'(n), 32'd6);
    check("t1_wr_sum", wr_sum, 32'hA);
    check("t1_rd_sum", rd_sum, 32'hA);
    check("t1_error", 32'(error), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_done_pulse", 32'(done), 32'd0);

    // Wrap at the top of memory, gaps in valid, start while busy ignored.
    expect_xfer(AW'(30718), 32'h10);
    expect_xfer(AW'(30719), 32'h20);
    expect_xfer(AW'(0), 32'h30);
    expect_xfer(AW'(1), 32'h40);
    do_start(AW'(30718), 4);
    step(1'b1, 32'h10, 1'b0);
    step(1'b0, 32'hDEAD, 1'b0);
    step(1'b1, 32'h20, 1'b0);
    step(1'b0, 32'hBEEF, 1'b0);
    start = 1'b1; base_addr = AW'(5); length = 16'd3;
    step(1'b1, 32'h30, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b0);
    wait_done(n);
    check("t2_done_lat", 32'(n), 32'd6);
    check("t2_wr_sum", wr_sum, 32'hA0);
    check("t2_rd_sum", rd_sum, 32'hA0);
    check("t2_error", 32'(error), 32'd0);

    // Zero length and illegal requests: no memory access.
    do_start(0, 0);
    wait_done(n);
    check("t3_len0_lat", 32'(n), 32'd1);
    check("t3_len0_err", 32'(error), 32'd0);
    do_start(0, 16'd30721);
    wait_done(n);
    check("t3_long_lat", 32'(n), 32'd1);
    check("t3_long_err", 32'(error), 32'd1);
    do_start(AW'(30720), 1);
    wait_done(n);
    check("t3_base_lat", 32'(n), 32'd1);
    check("t3_base_err", 32'(error), 32'd1);

    // Read-back corruption at address 2.
    for (int i = 0; i < 4; i++) expect_xfer(AW'(i), 32'(i + 5));
    corrupt = 1'b1;
    do_start(0, 4);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i + 5), 1'b0);
    wait_done(n);
    corrupt = 1'b0;
    check("t4_done_lat", 32'(n), 32'd6);
    check("t4_wr_sum", wr_sum, 32'h1A);
    check("t4_rd_sum", rd_sum, 32'h19);
    check("t4_error", 32'(error), 32'd1);

    // Abort after two of eight words, then a clean packet.
    wq.push_back('{a: AW'(100), d: 32'hA1});
    wq.push_back('{a: AW'(101), d: 32'hA2});
    do_start(AW'(100), 8);
    step(1'b1, 32'hA1, 1'b0);
    @(negedge clk);
    check("t5_err_cleared", 32'(error), 32'd0);
    step(1'b1, 32'hA2, 1'b0);
    step(1'b1, 32'hA3, 1'b1);
    @(negedge clk);
    check("t5_abort_ready", 32'(snk_ready), 32'd0);
    wait_done(n);
    check("t5_abort_lat", 32'(n), 32'd1);
    check("t5_abort_err", 32'(error), 32'd1);
    check("t5_abort_sum", wr_sum, 32'h143);
    tick();
    @(negedge clk);
    check("t5_idle", 32'(busy), 32'd0);
    expect_xfer(AW'(200), 32'h3);
    expect_xfer(AW'(201), 32'h4);
    do_start(AW'(200), 2);
    step(1'b1, 32'h3, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    wait_done(n);
    check("t5_new_lat", 32'(n), 32'd4);
    check("t5_new_err", 32'(error), 32'd0);
    check("t5_new_wr", wr_sum, 32'h7);
    check("t5_new_rd", rd_sum, 32'h7);
    check("t5_rq_empty", 32'(rq.size()), 32'd0);

    // Asynchronous reset during the read-back pass.
    for (int i = 0; i < 4; i++) expect_xfer(AW'(i), 32'(i + 9));
    do_start(0, 4);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i + 9), 1'b0);
    tick();
    snk_valid = 1'b0;
    @(negedge clk);
    check("t6_in_verify", 32'(mem_chipselect && !mem_write), 32'd1);
    check("t6_wq_empty", 32'(wq.size()), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_cs", 32'(mem_chipselect), 32'd0);
    check("t6_rst_wrsum", wr_sum, 32'd0);
    check("t6_rst_rdsum", rd_sum, 32'd0);
    rq.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_busy", 32'(busy), 32'd0);
    check("t6_post_done", 32'(done), 32'd0);
    check("t6_post_err", 32'(error), 32'd0);
    check("t6_post_sum", wr_sum | rd_sum, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
